// File: rtl/sipo_deser_if.sv
// sipo_deser_if: bundles the deserializer's control, serial, and output-handshake signals.
//   en     shift strobe, one beat per cycle high
//   clr    synchronous clear of datapath and flags
//   load   parallel preload of the shift register from pdata
//   pdata  preload value
//   si     serial beat; si[LANES-1] is the earliest-in-time bit
//   ready  downstream accepts data
//   sr     live shift register contents
//   count  beats received in the current word
//   data   last completed word, held
//   valid  data holds an unconsumed word
//   ovf    sticky: a completed word was dropped
//   parity even parity of the captured word (0 unless SIPO_PARITY_EN)
// slave modport is the deserializer side; master is the producer/consumer side.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LANES = 1
);
  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] pdata;
  logic [LANES-1:0] si;
  logic             ready;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ovf;
  logic             parity;

  modport slave (
    input  en, clr, load, pdata, si, ready,
    output sr, count, data, valid, ovf, parity
  );

  modport master (
    output en, clr, load, pdata, si, ready,
    input  sr, count, data, valid, ovf, parity
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with held output word and valid/ready handshake.
//   i_CLK  clock, rising edge
//   i_RST  synchronous active-high reset
//   bus    sipo_deser_if.slave: en/clr/load/pdata/si/ready in; sr/count/data/valid/ovf/parity out
// Parameters: WIDTH (word bits, multiple of LANES), LANES (bits per beat), MSB_FIRST (shift dir).
// Optional feature macro: SIPO_PARITY_EN registers the even parity of each captured word on
// bus.parity; when undefined bus.parity is tied to 0.
module sipo_deser #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  sipo_deser_if.slave   bus
);
  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic             complete;

  // Shifted value for one enabled beat
  if (LANES == WIDTH) begin : g_full_lane
    assign sr_shift = bus.si;
  end else if (MSB_FIRST == 0) begin : g_lsb_first
    assign sr_shift = {bus.si, sr_q[WIDTH-1:LANES]};
  end else begin : g_msb_first
    assign sr_shift = {sr_q[WIDTH-LANES-1:0], bus.si};
  end

  // Shift register and beat counter
  always_comb begin
    sr_d     = sr_q;
    count_d  = count_q;
    complete = 1'b0;
    if (bus.clr) begin
      sr_d    = '0;
      count_d = '0;
    end else if (bus.load) begin
      sr_d    = bus.pdata;
      count_d = '0;
    end else if (bus.en) begin
      sr_d = sr_shift;
      if (count_q == CW'(BEATS - 1)) begin
        count_d  = '0;
        complete = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Output word state machine; completed word is the post-edge SR value (sr_d)
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      state_d = StEmpty;
      data_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (complete) begin
            data_d  = sr_d;
            state_d = StFull;
          end
        end
        StFull: begin
          if (complete) begin
            if (bus.ready) data_d = sr_d;  // back-to-back transfer, stay full
            else           ovf_d  = 1'b1;  // pending word not taken: drop the new one
          end else if (bus.ready) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sr_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= StEmpty;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_q, parity_d;

  // Parity follows data_q exactly: loaded whenever data_d takes a new word
  always_comb begin
    parity_d = parity_q;
    if (bus.clr) begin
      parity_d = 1'b0;
    end else if (complete && ((state_q == StEmpty) || bus.ready)) begin
      parity_d = ^sr_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

  assign bus.sr    = sr_q;
  assign bus.count = count_q;
  assign bus.data  = data_q;
  assign bus.valid = (state_q == StFull);
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench for sipo_deser.
//   DUT a: WIDTH=10 LANES=1 MSB_FIRST=0.  DUT b: WIDTH=8 LANES=2 MSB_FIRST=1.
// Honours SIPO_PARITY_EN for the expected parity values.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(10), .LANES(1)) ia ();
  sipo_deser_if #(.WIDTH(8),  .LANES(2)) ib ();

  sipo_deser #(.WIDTH(10), .LANES(1), .MSB_FIRST(0)) u_a (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (ia)
  );

  sipo_deser #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_b (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (ib)
  );

  function automatic logic exp_par(input logic [31:0] w);
`ifdef SIPO_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT a: n beats of w, bit 0 first
  task automatic send_a(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ia.si = w[i];
      ia.en = 1'b1;
      tick();
    end
    ia.en = 1'b0;
  endtask

  // DUT b: n 2-bit beats of w, top pair first
  task automatic send_b(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ib.si = w[7-2*i -: 2];
      ib.en = 1'b1;
      tick();
    end
    ib.en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ia.en = 0; ia.clr = 0; ia.load = 0; ia.pdata = '0; ia.si = '0; ia.ready = 0;
    ib.en = 0; ib.clr = 0; ib.load = 0; ib.pdata = '0; ib.si = '0; ib.ready = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_sr", ia.sr, 0);
    chk("rst_a_count", ia.count, 0);
    chk("rst_a_data", ia.data, 0);
    chk("rst_a_valid", ia.valid, 0);
    chk("rst_a_ovf", ia.ovf, 0);
    chk("rst_a_par", ia.parity, 0);
    chk("rst_b_sr", ib.sr, 0);
    chk("rst_b_valid", ib.valid, 0);

    // 1: 10'h2A5 LSB first, ready high
    ia.ready = 1'b1;
    send_a(10'h2A5, 5);
    chk("t1_count5", ia.count, 5);
    send_a(10'h2A5 >> 5, 4);
    chk("t1_count9", ia.count, 9);
    chk("t1_valid_pre", ia.valid, 0);
    send_a(10'h2A5 >> 9, 1);
    chk("t1_valid", ia.valid, 1);
    chk("t1_data", ia.data, 10'h2A5);
    chk("t1_sr", ia.sr, 10'h2A5);
    chk("t1_count", ia.count, 0);
    chk("t1_ovf", ia.ovf, 0);
    chk("t1_par", ia.parity, exp_par(10'h2A5));
    tick();
    chk("t1_xfer_valid", ia.valid, 0);
    chk("t1_xfer_data", ia.data, 10'h2A5);

    // 5/6: pending word, then clear mid-word
    ia.ready = 1'b0;
    send_a(10'h003, 10);
    chk("t6_data003", ia.data, 10'h003);
    chk("t6_par003", ia.parity, exp_par(10'h003));
    send_a(10'h3FF, 3);
    chk("t5_count3", ia.count, 3);
    ia.clr = 1'b1;
    tick();
    ia.clr = 1'b0;
    chk("t5_clr_count", ia.count, 0);
    chk("t5_clr_sr", ia.sr, 0);
    chk("t5_clr_valid", ia.valid, 0);
    chk("t5_clr_data", ia.data, 0);
    chk("t5_clr_par", ia.parity, 0);
    send_a(10'h155, 9);
    chk("t5_clr_valid9", ia.valid, 0);
    send_a(10'h155 >> 9, 1);
    chk("t5_clr_valid10", ia.valid, 1);
    chk("t5_clr_data10", ia.data, 10'h155);

    // 5: reset mid-word
    send_a(10'h3FF, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_count", ia.count, 0);
    chk("t5_rst_sr", ia.sr, 0);
    chk("t5_rst_valid", ia.valid, 0);
    chk("t5_rst_data", ia.data, 0);
    send_a(10'h2A5, 9);
    chk("t5_rst_valid9", ia.valid, 0);
    send_a(10'h2A5 >> 9, 1);
    chk("t5_rst_data10", ia.data, 10'h2A5);

    // 5: load mid-word keeps the pending word
    send_a(10'h3FF, 3);
    ia.load  = 1'b1;
    ia.pdata = 10'h3FF;
    tick();
    ia.load = 1'b0;
    chk("t5_ld_count", ia.count, 0);
    chk("t5_ld_sr", ia.sr, 10'h3FF);
    chk("t5_ld_valid", ia.valid, 1);
    chk("t5_ld_data", ia.data, 10'h2A5);
    send_a(10'h0F0, 9);
    chk("t5_ld_count9", ia.count, 9);
    chk("t5_ld_ovf9", ia.ovf, 0);
    send_a(10'h0F0 >> 9, 1);
    chk("t5_ld_sr10", ia.sr, 10'h0F0);
    chk("t5_ld_ovf10", ia.ovf, 1);
    chk("t5_ld_data10", ia.data, 10'h2A5);

    // 2: MSB-first, 2 lanes, idle gaps
    ib.ready = 1'b1;
    send_b(8'hB1, 1);
    chk("t2_sr1", ib.sr, 8'h02);
    chk("t2_count1", ib.count, 1);
    tick();
    send_b(8'hB1 << 2, 1);
    chk("t2_sr2", ib.sr, 8'h0B);
    tick();
    tick();
    send_b(8'hB1 << 4, 1);
    chk("t2_sr3", ib.sr, 8'h2C);
    chk("t2_valid3", ib.valid, 0);
    tick();
    send_b(8'hB1 << 6, 1);
    chk("t2_sr4", ib.sr, 8'hB1);
    chk("t2_data", ib.data, 8'hB1);
    chk("t2_valid", ib.valid, 1);
    chk("t2_count", ib.count, 0);
    chk("t2_par", ib.parity, exp_par(8'hB1));
    tick();
    chk("t2_xfer_valid", ib.valid, 0);

    // 3: overflow with ready low
    ib.ready = 1'b0;
    send_b(8'h11, 4);
    chk("t3_data11", ib.data, 8'h11);
    chk("t3_ovf11", ib.ovf, 0);
    send_b(8'h22, 4);
    chk("t3_data", ib.data, 8'h11);
    chk("t3_valid", ib.valid, 1);
    chk("t3_ovf", ib.ovf, 1);
    ib.ready = 1'b1;
    tick();
    ib.ready = 1'b0;
    chk("t3_xfer_valid", ib.valid, 0);
    chk("t3_ovf_sticky", ib.ovf, 1);
    tick();
    chk("t3_ovf_sticky2", ib.ovf, 1);
    ib.clr = 1'b1;
    tick();
    ib.clr = 1'b0;
    chk("t3_clr_ovf", ib.ovf, 0);

    // 4: back-to-back transfer and capture
    send_b(8'h22, 4);
    chk("t4_data22", ib.data, 8'h22);
    send_b(8'h33, 3);
    ib.ready = 1'b1;
    send_b(8'h33 << 6, 1);
    chk("t4_valid", ib.valid, 1);
    chk("t4_data", ib.data, 8'h33);
    chk("t4_ovf", ib.ovf, 0);
    chk("t4_par", ib.parity, exp_par(8'h33));
    tick();
    chk("t4_xfer_valid", ib.valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
